// File: rtl/cla_seq_adder_if.sv
// Handshake and data bundle for the sequential CLA adder.
//   master: drives start/sub/a/b, observes busy/done/result/flags (ALU control side)
//   slave : the adder itself
//   start  - request; sampled only when the adder is idle or in its done cycle
//   sub    - 0 = a+b, 1 = a-b
//   a, b   - operands
//   busy   - slices being computed
//   done   - one-cycle pulse, result and flags valid from this cycle on
//   result - sum/difference; cout/ovf/zero - carry (no-borrow on sub), signed overflow, zero
interface cla_seq_adder_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output start, sub, a, b,
    input  busy, done, result, cout, ovf, zero
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, result, cout, ovf, zero
  );
endinterface

// File: rtl/cla_seq_adder.sv
// Multi-cycle WIDTH-bit add/subtract unit. A single 4-bit carry-lookahead slice is reused
// across the operand, least-significant nibble first, with the ripple carry held in a
// register between cycles. Latency from accepted start to done is WIDTH/4 cycles.
//   clk  - clock, all state on rising edge
//   rst  - synchronous active-high reset
//   bus  - cla_seq_adder_if slave: start/sub/a/b in; busy/done/result/cout/ovf/zero out
// All outputs come straight from registers.
module cla_seq_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic           clk,
  input  logic           rst,
  cla_seq_adder_if.slave bus
);

  localparam int unsigned N    = WIDTH / 4;
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;

  if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
    $error("cla_seq_adder: WIDTH must be a multiple of 4 and at least 8");
  end

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  op_a_q, op_a_d;
  logic [WIDTH-1:0]  op_b_q, op_b_d;
  logic              carry_q, carry_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;
  logic              zero_q, zero_d;

  logic [3:0]        slice_a, slice_b, slice_g, slice_p, slice_sum;
  logic [4:0]        slice_c;
  logic [WIDTH-1:0]  result_upd;
  logic              last_slice;

  // Select the current nibble of each operand.
  always_comb begin
    slice_a = '0;
    slice_b = '0;
    for (int k = 0; k < int'(N); k++) begin
      if (idx_q == IdxW'(k)) begin
        slice_a = op_a_q[4*k +: 4];
        slice_b = op_b_q[4*k +: 4];
      end
    end
  end

  // 4-bit carry-lookahead slice.
  always_comb begin
    slice_g    = slice_a & slice_b;
    slice_p    = slice_a ^ slice_b;
    slice_c[0] = carry_q;
    slice_c[1] = slice_g[0] | (slice_p[0] & slice_c[0]);
    slice_c[2] = slice_g[1] | (slice_p[1] & slice_g[0]) | (slice_p[1] & slice_p[0] & slice_c[0]);
    slice_c[3] = slice_g[2] | (slice_p[2] & slice_g[1]) | (slice_p[2] & slice_p[1] & slice_g[0])
               | (slice_p[2] & slice_p[1] & slice_p[0] & slice_c[0]);
    slice_c[4] = slice_g[3] | (slice_p[3] & slice_g[2]) | (slice_p[3] & slice_p[2] & slice_g[1])
               | (slice_p[3] & slice_p[2] & slice_p[1] & slice_g[0])
               | (slice_p[3] & slice_p[2] & slice_p[1] & slice_p[0] & slice_c[0]);
    slice_sum  = slice_p ^ slice_c[3:0];
  end

  // Result with the current slice merged in; on the last slice this is the full answer,
  // which lets the zero flag be computed in the same edge that enters DONE.
  always_comb begin
    result_upd = result_q;
    for (int k = 0; k < int'(N); k++) begin
      if (idx_q == IdxW'(k)) begin
        result_upd[4*k +: 4] = slice_sum;
      end
    end
  end

  assign last_slice = (idx_q == IdxW'(N - 1));

  always_comb begin
    state_d  = state_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    carry_d  = carry_q;
    idx_d    = idx_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          state_d  = StRun;
          op_a_d   = bus.a;
          // Subtraction as a + ~b + 1: the +1 enters as the initial carry.
          op_b_d   = bus.sub ? ~bus.b : bus.b;
          carry_d  = bus.sub;
          idx_d    = '0;
          result_d = '0;
          cout_d   = 1'b0;
          ovf_d    = 1'b0;
          zero_d   = 1'b0;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        result_d = result_upd;
        carry_d  = slice_c[4];
        idx_d    = idx_q + IdxW'(1);
        if (last_slice) begin
          state_d = StDone;
          cout_d  = slice_c[4];
          ovf_d   = (op_a_q[WIDTH-1] == op_b_q[WIDTH-1]) & (slice_sum[3] != op_a_q[WIDTH-1]);
          zero_d  = (result_upd == '0);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      op_a_q   <= '0;
      op_b_q   <= '0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      carry_q  <= carry_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign bus.busy   = (state_q == StRun);
  assign bus.done   = (state_q == StDone);
  assign bus.result = result_q;
  assign bus.cout   = cout_q;
  assign bus.ovf    = ovf_q;
  assign bus.zero   = zero_q;

endmodule
